// File: rtl/mips_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit_if
// Instruction-memory read bus between the fetch unit and instruction memory.
//   mem_req   : read request, held while the fetch unit waits for a word
//   mem_addr  : read address (the fetch unit's PC)
//   mem_rdata : returned instruction word, valid when mem_ready=1
//   mem_ready : memory has accepted the request and rdata is valid
// The fetch unit connects through the master modport, memory through slave.
// ---------------------------------------------------------------------------
interface mips_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
// Multi-cycle MIPS instruction-fetch stage sitting just upstream of the
// CONTROLLER. Owns the PC and the instruction register (IR), prefetches the
// next word from a variable-latency instruction memory into a one-word
// buffer, and raises stall when the controller asks for an IR load before
// that word has arrived.
//
// Ports:
//   clk, reset           : rising-edge clock, asynchronous active-low reset
//   pcen, irwrite, pcsrc : PC write enable, IR load request, next-PC select
//   aluresult, aluout    : PC+4 / computed target, registered branch target
//   mem                  : instruction-memory bus (mips_fetch_unit_if.master)
//   pc, instr            : PC register and instruction register
//   op, funct            : instr[31:26] and instr[5:0]
//   stall                : IR load requested without a buffered word, or error
//   fetch_err            : sticky memory-timeout flag, cleared only by reset
//
// Optional feature (define FETCH_PERF_EN):
//   adds output stall_count[15:0], a saturating count of stalled cycles.
// ---------------------------------------------------------------------------
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pcen,
    input  logic               irwrite,
    input  logic [1:0]         pcsrc,
    input  logic [31:0]        aluresult,
    input  logic [31:0]        aluout,
    mips_fetch_unit_if.master  mem,
    output logic [31:0]        pc,
    output logic [31:0]        instr,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic               stall,
    output logic               fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        stall_count
`endif
);

    // The wait counter must be able to hold MAX_WAIT itself.
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READY,
        WAIT_PC,
        ERR
    } fetch_state_t;

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [31:0]       mem_buf;
    logic              buf_valid;
    logic [WAIT_W-1:0] wait_count;
    logic [31:0]       next_pc;
    logic              req_active;
    logic              pc_write;
    logic              ir_load;
    logic              capture;

    assign mem.mem_req  = req_active;
    assign mem.mem_addr = pc;
    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign fetch_err    = (state == ERR);

    // Next-PC selection as driven by the controller's pcsrc. The jump form
    // keeps the PC's top nibble and uses the current IR's 26-bit index.
    always_comb begin
        next_pc = pc;
        case (pcsrc)
            2'b00:   next_pc = aluresult;
            2'b01:   next_pc = aluout;
            2'b10:   next_pc = {pc[31:28], instr[25:0], 2'b00};
            default: next_pc = pc;
        endcase
    end

    // State register; reset drops mem_req immediately because mem_req is
    // decoded from the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. A PC update while requesting restarts
    // the request at the new address and drops any coincident response, so
    // pcen takes priority over mem_ready. The buffer is only ever valid in
    // READY, so irwrite anywhere else shows up as a stall.
    always_comb begin
        next_state = state;
        req_active = 1'b0;
        stall      = irwrite & ~buf_valid;
        pc_write   = pcen;
        ir_load    = irwrite & buf_valid;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                next_state = REQ;
            end
            REQ: begin
                req_active = 1'b1;
                if (pcen) begin
                    next_state = REQ;
                end else if (mem.mem_ready) begin
                    capture    = 1'b1;
                    next_state = READY;
                end else if (wait_count == WAIT_LAST) begin
                    next_state = ERR;
                end
            end
            READY: begin
                if (pcen) begin
                    next_state = REQ;
                end else if (irwrite) begin
                    next_state = WAIT_PC;
                end
            end
            WAIT_PC: begin
                if (pcen) begin
                    next_state = REQ;
                end
            end
            ERR: begin
                stall    = 1'b1;
                pc_write = 1'b0;
                ir_load  = 1'b0;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // PC, IR, prefetch buffer and timeout counter. The buffer is invalidated
    // either when it is consumed by an IR load or when the PC moves away
    // from the address it was fetched from.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            instr      <= '0;
            mem_buf    <= '0;
            buf_valid  <= 1'b0;
            wait_count <= '0;
        end else begin
            if (pc_write) begin
                pc <= next_pc;
            end
            if (ir_load) begin
                instr <= mem_buf;
            end
            if (capture) begin
                mem_buf   <= mem.mem_rdata;
                buf_valid <= 1'b1;
            end else if (state == READY && (irwrite || pcen)) begin
                buf_valid <= 1'b0;
            end
            if (state == REQ && !pcen && !mem.mem_ready) begin
                wait_count <= wait_count + 1'b1;
            end else begin
                wait_count <= '0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating count of stalled cycles for performance monitoring.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_unit
// Directed scenarios with literal expectations, followed by randomized
// controller/memory traffic. A queue-based reference model tracks what the
// fetch stage must present; a negedge process compares every output to it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_fetch_unit;

    localparam int MAX_WAIT = 15;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        pcen      = 1'b0;
    logic        irwrite   = 1'b0;
    logic [1:0]  pcsrc     = 2'b00;
    logic [31:0] aluresult = 32'h0;
    logic [31:0] aluout    = 32'h0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        stall;
    logic        fetch_err;
`ifdef FETCH_PERF_EN
    logic [15:0] stall_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    mips_fetch_unit_if mem_bus();

    mips_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pcen      (pcen),
        .irwrite   (irwrite),
        .pcsrc     (pcsrc),
        .aluresult (aluresult),
        .aluout    (aluout),
        .mem       (mem_bus),
        .pc        (pc),
        .instr     (instr),
        .op        (op),
        .funct     (funct),
        .stall     (stall),
        .fetch_err (fetch_err)
`ifdef FETCH_PERF_EN
        ,
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the PC, the IR, a queue holding at most one fetched
    // word, and flags for "just out of reset", "request outstanding" and
    // "timed out".
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_words[$];
    bit          m_fresh;
    bit          m_reqing;
    bit          m_err;
    int          m_waits;
    int          m_stall_count;

    function automatic bit expStall();
        return m_err || (irwrite && m_words.size() == 0);
    endfunction

    task automatic modelStep();
        logic [31:0] target;
        if (!reset) begin
            m_pc          = 32'h0;
            m_instr       = 32'h0;
            m_words.delete();
            m_fresh       = 1'b1;
            m_reqing      = 1'b0;
            m_err         = 1'b0;
            m_waits       = 0;
            m_stall_count = 0;
            return;
        end
        case (pcsrc)
            2'd0:    target = aluresult;
            2'd1:    target = aluout;
            2'd2:    target = (m_pc & 32'hF000_0000) | ((m_instr << 2) & 32'h0FFF_FFFC);
            default: target = m_pc;
        endcase
        if (expStall() && m_stall_count < 65535) m_stall_count++;
        if (m_err) return;
        if (irwrite && m_words.size() > 0) m_instr = m_words.pop_front();
        if (m_fresh) begin
            m_fresh  = 1'b0;
            m_reqing = 1'b1;
            m_waits  = 0;
            if (pcen) m_pc = target;
        end else if (m_reqing) begin
            if (pcen) begin
                m_pc    = target;
                m_waits = 0;
            end else if (mem_bus.mem_ready) begin
                m_words.push_back(mem_bus.mem_rdata);
                m_reqing = 1'b0;
                m_waits  = 0;
            end else begin
                m_waits++;
                if (m_waits >= MAX_WAIT) m_err = 1'b1;
            end
        end else if (pcen) begin
            m_pc = target;
            m_words.delete();
            m_reqing = 1'b1;
            m_waits  = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("mem_req",   32'(mem_bus.mem_req), 32'(m_reqing && !m_err && !m_fresh));
            checkOutput("mem_addr",  mem_bus.mem_addr, m_pc);
            checkOutput("pc",        pc, m_pc);
            checkOutput("instr",     instr, m_instr);
            checkOutput("op",        32'(op), m_instr / 32'h0400_0000);
            checkOutput("funct",     32'(funct), m_instr % 64);
            checkOutput("stall",     32'(stall), 32'(expStall()));
            checkOutput("fetch_err", 32'(fetch_err), 32'(m_err));
`ifdef FETCH_PERF_EN
            checkOutput("stall_count", 32'(stall_count), 32'(m_stall_count));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic p_pcen, input logic p_irwrite,
                                 input logic [1:0] p_pcsrc, input logic [31:0] p_aluresult,
                                 input logic [31:0] p_aluout, input logic p_ready,
                                 input logic [31:0] p_rdata);
        pcen              = p_pcen;
        irwrite           = p_irwrite;
        pcsrc             = p_pcsrc;
        aluresult         = p_aluresult;
        aluout            = p_aluout;
        mem_bus.mem_ready = p_ready;
        mem_bus.mem_rdata = p_rdata;
    endtask

    initial begin
        int err_cycles;
        int ready_pct;
        int pcen_pct;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;

        // Reset state
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_pc",      pc, 32'h0);
        checkOutput("rst_instr",   instr, 32'h0);
        checkOutput("rst_mem_req", 32'(mem_bus.mem_req), 32'h0);
        checkOutput("rst_stall",   32'(stall), 32'h0);
        #10 reset = 1'b1;
        tick();
        tick();
        checkOutput("req_after_rst",  32'(mem_bus.mem_req), 32'h1);
        checkOutput("addr_after_rst", mem_bus.mem_addr, 32'h0);

        // Zero-wait fetch, then IR load with PC+4 and prefetch
        applyStimulus(0, 0, 2'b00, 0, 0, 1, 32'h8C01_0004);
        tick();
        applyStimulus(1, 1, 2'b00, 32'h4, 0, 0, 0);
        #1 checkOutput("ready_no_stall", 32'(stall), 32'h0);
        tick();
        checkOutput("lw_instr",  instr, 32'h8C01_0004);
        checkOutput("lw_op",     32'(op), 32'h23);
        checkOutput("pc_plus4",  pc, 32'h4);
        checkOutput("prefetch_req",  32'(mem_bus.mem_req), 32'h1);
        checkOutput("prefetch_addr", mem_bus.mem_addr, 32'h4);

        // Three-cycle memory latency with irwrite held
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 2'b00, 0, 0, (i == 2), 32'h2002_0005);
            #1 checkOutput("latency_stall", 32'(stall), 32'h1);
            tick();
        end
        applyStimulus(0, 1, 2'b00, 0, 0, 0, 0);
        #1 checkOutput("latency_release", 32'(stall), 32'h0);
        tick();
        checkOutput("latency_instr", instr, 32'h2002_0005);
`ifdef FETCH_PERF_EN
        checkOutput("latency_stall_count", 32'(stall_count), 32'h3);
`endif

        // PC redirect coincident with mem_ready discards the word
        applyStimulus(1, 0, 2'b00, 32'h8, 0, 0, 0);
        tick();
        checkOutput("pc_eight", pc, 32'h8);
        applyStimulus(1, 0, 2'b01, 0, 32'h40, 1, 32'hDEAD_BEEF);
        tick();
        checkOutput("redirect_addr",  mem_bus.mem_addr, 32'h40);
        checkOutput("redirect_req",   32'(mem_bus.mem_req), 32'h1);
        checkOutput("redirect_instr", instr, 32'h2002_0005);

        // Jump target from the IR
        applyStimulus(1, 0, 2'b00, 32'h14, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 2'b00, 0, 0, 1, 32'h0800_0010);
        tick();
        applyStimulus(0, 1, 2'b00, 0, 0, 0, 0);
        tick();
        checkOutput("j_instr", instr, 32'h0800_0010);
        applyStimulus(1, 0, 2'b10, 0, 0, 0, 0);
        tick();
        checkOutput("j_target", pc, 32'h40);
        applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);

        // Memory timeout
        for (int i = 1; i <= MAX_WAIT; i++) begin
            tick();
            if (i == MAX_WAIT - 1) checkOutput("pre_timeout_err", 32'(fetch_err), 32'h0);
        end
        checkOutput("timeout_err",   32'(fetch_err), 32'h1);
        checkOutput("timeout_stall", 32'(stall), 32'h1);
        checkOutput("timeout_req",   32'(mem_bus.mem_req), 32'h0);
        applyStimulus(1, 1, 2'b00, 32'h100, 0, 1, 32'h1234_5678);
        tick();
        checkOutput("err_pc_frozen",    pc, 32'h40);
        checkOutput("err_instr_frozen", instr, 32'h0800_0010);
        checkOutput("err_sticky",       32'(fetch_err), 32'h1);
        applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
        reset = 1'b0;
        #1 checkOutput("err_cleared", 32'(fetch_err), 32'h0);
        tick();
        reset = 1'b1;

        // Reset in the middle of a request cycle
        tick();
        checkOutput("req_before_midreset", 32'(mem_bus.mem_req), 32'h1);
        #3 reset = 1'b0;
        #1 checkOutput("midreset_req", 32'(mem_bus.mem_req), 32'h0);
        tick();
        reset = 1'b1;

        // Randomized traffic with occasional resets
        err_cycles = 0;
        ready_pct  = 50;
        pcen_pct   = 25;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       begin ready_pct = 10; pcen_pct = 3;  end
                    1:       begin ready_pct = 50; pcen_pct = 25; end
                    default: begin ready_pct = 90; pcen_pct = 25; end
                endcase
            end
            err_cycles = m_err ? err_cycles + 1 : 0;
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 299) == 0 || err_cycles > 6) begin
                reset = 1'b0;
            end
            applyStimulus($urandom_range(0, 99) < pcen_pct,
                          $urandom_range(0, 99) < 45,
                          2'($urandom_range(0, 3)),
                          $urandom, $urandom,
                          $urandom_range(0, 99) < ready_pct,
                          $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
